wqe_segmenter: RTL and testbench
================================

Name: wqe_segmenter

Overview:
- Transport-side consumer of the group scheduler's WQE-cache interface.
- Pops one WQE per request and cuts it into MTU-sized packet descriptors for the packet builder.
- Latency-sensitive (LS) WQEs are segmented to completion in one visit.
- Bulk (BS) WQEs get exactly one MTU segment per visit. The remainder is written back to the station-buffer slot as a partial WQE (pWQE), or the slot is freed when the WQE is exhausted. This enforces per-visit isolation between BS flows.

Parameters:
- WQE_WIDTH, 512, WQE bit width.
- PWQE_SLOT_NUM, 4, number of station-buffer slots.
- PWQE_BUF_ADDR_WIDTH, 2, slot address width.
- LEN_WIDTH, 32, byte-length field width.
- MTU_LOG2, 12, log2 of the MTU in bytes (4096).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_wqe_cache_empty  in  1  scheduler has no WQE ready.
- o_wqe_cache_rd  out  1  one-cycle pop request.
- i_wqe_val  in  1  WQE delivered this cycle.
- i_wqe_type  in  1  0=LS, 1=BS.
- i_wqe_addr  in  PWQE_BUF_ADDR_WIDTH  BS slot address.
- i_wqe  in  WQE_WIDTH  WQE body.
- o_pwqe_wb  out  1  one-cycle pWQE write-back strobe.
- o_pwqe_addr  out  PWQE_BUF_ADDR_WIDTH  write-back slot.
- o_pwqe  out  WQE_WIDTH  updated WQE.
- o_slot_free  out  1  one-cycle slot release strobe.
- o_slot_free_addr  out  PWQE_BUF_ADDR_WIDTH  released slot.
- o_pkt_val  out  1  packet descriptor valid.
- i_pkt_rdy  in  1  downstream accepts the descriptor.
- o_pkt_laddr  out  64  local address.
- o_pkt_raddr  out  64  remote address.
- o_pkt_len  out  LEN_WIDTH  segment bytes.
- o_pkt_type  out  1  LS/BS of the source WQE.
- o_pkt_first, o_pkt_last  out  1  first/last segment of the WQE.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- WQE layout: [63:0] laddr, [127:64] raddr, [127+LEN_WIDTH:128] remaining length, [WQE_WIDTH-1:160] opaque. Opaque bits are copied unchanged into o_pwqe.
- First-segment flag: bit 511 of the WQE. Set to 1 on write-back. A BS WQE with bit 511 = 0 is on its first visit.
- Reset: all outputs 0; FSM in IDLE; o_err cleared.
- IDLE: if !i_wqe_cache_empty, assert o_wqe_cache_rd for exactly 1 cycle, then go to WAIT.
- WAIT: hold until i_wqe_val, with any latency ≥1. Latch type, addr and fields, then go to EMIT.
- EMIT:
  - seg = min(remaining, 2^MTU_LOG2).
  - Drive o_pkt_val with the fields, stable until i_pkt_rdy is seen.
  - On the handshake: laddr += seg, raddr += seg (modulo 2^64), remaining -= seg.
  - o_pkt_last = 1 when remaining ≤ MTU.
  - LS: stay in EMIT until the last segment, then go to IDLE. No write-back and no free.
  - BS: after one segment go to DONE.
- DONE, BS only:
  - If remaining > 0, pulse o_pwqe_wb with the updated WQE (bit 511 set).
  - Otherwise pulse o_slot_free.
  - Exactly one of the two per visit. Then go to IDLE.
- Zero length: one descriptor with len=0, first=1, last=1. BS frees its slot.
- Exactly MTU length: one descriptor, last=1. BS frees its slot, no write-back.
- o_pkt_val may be back-to-back across LS segments with zero bubble when i_pkt_rdy=1.
- i_wqe_val outside WAIT: ignored, o_err set (sticky until reset).
- i_wqe_cache_empty rising while in WAIT: no effect; the pending pop is still awaited.
- Reset mid-operation: immediate return to IDLE; in-flight WQE discarded; no strobes.

Decomposition:
- Package wqe_pkg holds:
  - WQE field offset/width constants (LADDR_LSB, RADDR_LSB, LEN_LSB, FIRST_BIT).
  - LS/BS type encoding constants.
  - FSM state enum (IDLE, WAIT, EMIT, DONE).
- One natural sub-module, seg_calc: combinational min(remaining, MTU), the next laddr/raddr/remaining values, and the last flag.

Test Plan:
- LS WQE, len=10000, MTU 4096, i_pkt_rdy=1 -> 3 descriptors: len 4096/4096/1808, first on #1, last on #3. Addresses +0/+4096/+8192. No wb and no free.
- BS WQE in slot 2, len=9000 -> 1 descriptor of len 4096. o_pwqe_wb with addr 2, len 4904, laddr +4096, bit 511 set. Re-deliver it -> wb with len 808, first=0. Third visit -> len 808, last=1, o_slot_free addr 2.
- BS len=4096 in slot 0 -> single descriptor with last=1, o_slot_free addr 0, o_pwqe_wb never asserted.
- Len=0 LS and BS -> len=0 descriptor with first=last=1; BS frees its slot.
- i_pkt_rdy held low 7 cycles -> o_pkt_val and all fields stable for those cycles, no second o_wqe_cache_rd. Spurious i_wqe_val in IDLE -> o_err=1 and remains set.
- Reset asserted during EMIT of a 3-segment LS WQE -> all outputs 0 asynchronously. After release, the next pop resumes cleanly with no stale segments.

Source files
------------

// File: rtl/wqe_pkg.sv
// rtl/wqe_pkg.sv - shared WQE field layout, type encoding and FSM state for the WQE segmenter
//
// Purpose: single place for the WQE bit layout so the segmenter and its
// arithmetic helper agree on where each field lives.
//   LADDR_LSB / RADDR_LSB : 64-bit local / remote address fields
//   LEN_LSB               : remaining byte-length field (LEN_WIDTH wide)
//   FIRST_BIT             : "already visited" flag at the top of a 512-bit WQE
//   TYPE_LS / TYPE_BS     : latency-sensitive / bulk encoding of i_wqe_type
//   state_e               : segmenter FSM states

package wqe_pkg;

    localparam int ADDR_W    = 64;
    localparam int LADDR_LSB = 0;
    localparam int RADDR_LSB = 64;
    localparam int LEN_LSB   = 128;
    localparam int FIRST_BIT = 511;

    localparam logic TYPE_LS = 1'b0;
    localparam logic TYPE_BS = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seg_calc.sv
// rtl/seg_calc.sv - combinational MTU cut: segment size, advanced addresses, remainder, last flag
//
// Ports:
//   laddr_i, raddr_i   current local / remote addresses
//   rem_i              bytes still to send
//   seg_o              min(rem_i, MTU)
//   laddr_nxt_o        laddr_i + seg_o (wraps modulo 2^64)
//   raddr_nxt_o        raddr_i + seg_o (wraps modulo 2^64)
//   rem_nxt_o          rem_i - seg_o
//   last_o             this segment finishes the WQE (rem_i <= MTU)

module seg_calc
    import wqe_pkg::*;
#(
    parameter int LEN_WIDTH = 32,
    parameter int MTU_LOG2  = 12
) (
    input  logic [ADDR_W-1:0]    laddr_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    input  logic [LEN_WIDTH-1:0] rem_i,
    output logic [LEN_WIDTH-1:0] seg_o,
    output logic [ADDR_W-1:0]    laddr_nxt_o,
    output logic [ADDR_W-1:0]    raddr_nxt_o,
    output logic [LEN_WIDTH-1:0] rem_nxt_o,
    output logic                 last_o
);

    localparam logic [LEN_WIDTH-1:0] MTU = LEN_WIDTH'(1) << MTU_LOG2;

    always_comb begin
        last_o      = (rem_i <= MTU);
        seg_o       = last_o ? rem_i : MTU;
        rem_nxt_o   = rem_i - seg_o;
        laddr_nxt_o = laddr_i + ADDR_W'(seg_o);
        raddr_nxt_o = raddr_i + ADDR_W'(seg_o);
    end

endmodule

// File: rtl/wqe_segmenter.sv
// rtl/wqe_segmenter.sv - pops WQEs from the scheduler cache and cuts them into MTU packet descriptors
//
// LS WQEs are segmented to completion in one visit; BS WQEs emit one segment
// per visit and then either write the remainder back to their station-buffer
// slot (first flag set) or free the slot.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_wqe_cache_empty / o_wqe_cache_rd scheduler has nothing / one-cycle pop
//   i_wqe_val, i_wqe_type, i_wqe_addr, i_wqe   delivered WQE (type 0=LS 1=BS)
//   o_pwqe_wb, o_pwqe_addr, o_pwqe    one-cycle partial-WQE write-back
//   o_slot_free, o_slot_free_addr     one-cycle slot release
//   o_pkt_val / i_pkt_rdy             descriptor handshake
//   o_pkt_laddr, o_pkt_raddr, o_pkt_len, o_pkt_type, o_pkt_first, o_pkt_last
//   o_err                             sticky protocol error

module wqe_segmenter
    import wqe_pkg::*;
#(
    parameter int WQE_WIDTH           = 512,
    parameter int PWQE_SLOT_NUM       = 4,
    parameter int PWQE_BUF_ADDR_WIDTH = 2,
    parameter int LEN_WIDTH           = 32,
    parameter int MTU_LOG2            = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wqe_cache_empty,
    output logic                           o_wqe_cache_rd,
    input  logic                           i_wqe_val,
    input  logic                           i_wqe_type,
    input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_wqe_addr,
    input  logic [WQE_WIDTH-1:0]           i_wqe,
    output logic                           o_pwqe_wb,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_pwqe_addr,
    output logic [WQE_WIDTH-1:0]           o_pwqe,
    output logic                           o_slot_free,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_slot_free_addr,
    output logic                           o_pkt_val,
    input  logic                           i_pkt_rdy,
    output logic [63:0]                    o_pkt_laddr,
    output logic [63:0]                    o_pkt_raddr,
    output logic [LEN_WIDTH-1:0]           o_pkt_len,
    output logic                           o_pkt_type,
    output logic                           o_pkt_first,
    output logic                           o_pkt_last,
    output logic                           o_err
);

    // Opaque region sits between the length field and the first flag.
    localparam int OPQ_W = WQE_WIDTH - 1 - LEN_LSB - LEN_WIDTH;
    localparam int FB    = WQE_WIDTH - 1;
    localparam logic [PWQE_BUF_ADDR_WIDTH:0] SLOT_LIMIT =
        (PWQE_BUF_ADDR_WIDTH + 1)'(PWQE_SLOT_NUM);

    state_e                         state_q, state_d;
    logic                           rd_q, rd_d;
    logic                           err_q, err_d;
    logic                           type_q, type_d;
    logic [PWQE_BUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0]              laddr_q, laddr_d;
    logic [ADDR_W-1:0]              raddr_q, raddr_d;
    logic [LEN_WIDTH-1:0]           rem_q, rem_d;
    logic [OPQ_W-1:0]               opaque_q, opaque_d;
    logic                           first_q, first_d;

    logic [LEN_WIDTH-1:0]           seg;
    logic [ADDR_W-1:0]              laddr_nxt;
    logic [ADDR_W-1:0]              raddr_nxt;
    logic [LEN_WIDTH-1:0]           rem_nxt;
    logic                           seg_last;
    logic                           slot_oob;

    seg_calc #(
        .LEN_WIDTH (LEN_WIDTH),
        .MTU_LOG2  (MTU_LOG2)
    ) u_seg_calc (
        .laddr_i     (laddr_q),
        .raddr_i     (raddr_q),
        .rem_i       (rem_q),
        .seg_o       (seg),
        .laddr_nxt_o (laddr_nxt),
        .raddr_nxt_o (raddr_nxt),
        .rem_nxt_o   (rem_nxt),
        .last_o      (seg_last)
    );

    // A BS WQE naming a slot beyond the configured station buffer is flagged;
    // it is still processed so the scheduler is never left waiting.
    assign slot_oob = ({1'b0, i_wqe_addr} >= SLOT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            type_q   <= TYPE_LS;
            addr_q   <= '0;
            laddr_q  <= '0;
            raddr_q  <= '0;
            rem_q    <= '0;
            opaque_q <= '0;
            first_q  <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            err_q    <= err_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            laddr_q  <= laddr_d;
            raddr_q  <= raddr_d;
            rem_q    <= rem_d;
            opaque_q <= opaque_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = 1'b0;
        err_d    = err_q;
        type_d   = type_q;
        addr_d   = addr_q;
        laddr_d  = laddr_q;
        raddr_d  = raddr_q;
        rem_d    = rem_q;
        opaque_d = opaque_q;
        first_d  = first_q;

        o_wqe_cache_rd   = rd_q;
        o_pwqe_wb        = 1'b0;
        o_pwqe_addr      = '0;
        o_pwqe           = '0;
        o_slot_free      = 1'b0;
        o_slot_free_addr = '0;
        o_pkt_val        = 1'b0;
        o_pkt_laddr      = '0;
        o_pkt_raddr      = '0;
        o_pkt_len        = '0;
        o_pkt_type       = 1'b0;
        o_pkt_first      = 1'b0;
        o_pkt_last       = 1'b0;
        o_err            = err_q;

        if (i_wqe_val && (state_q != WAIT)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // The pop strobe is registered so it leaves the block glitch-free
                // and is forced low the instant reset asserts.
                if (!i_wqe_cache_empty) begin
                    rd_d    = 1'b1;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (i_wqe_val) begin
                    type_d   = i_wqe_type;
                    addr_d   = i_wqe_addr;
                    laddr_d  = i_wqe[LADDR_LSB +: ADDR_W];
                    raddr_d  = i_wqe[RADDR_LSB +: ADDR_W];
                    rem_d    = i_wqe[LEN_LSB +: LEN_WIDTH];
                    opaque_d = i_wqe[FB-1 -: OPQ_W];
                    first_d  = ~i_wqe[FB];
                    if ((i_wqe_type == TYPE_BS) && slot_oob) begin
                        err_d = 1'b1;
                    end
                    state_d  = EMIT;
                end
            end

            EMIT: begin
                o_pkt_val   = 1'b1;
                o_pkt_laddr = laddr_q;
                o_pkt_raddr = raddr_q;
                o_pkt_len   = seg;
                o_pkt_type  = type_q;
                o_pkt_first = first_q;
                o_pkt_last  = seg_last;
                if (i_pkt_rdy) begin
                    laddr_d = laddr_nxt;
                    raddr_d = raddr_nxt;
                    rem_d   = rem_nxt;
                    first_d = 1'b0;
                    // BS gets exactly one segment per visit; LS keeps going
                    // back-to-back until the last one.
                    if (type_q == TYPE_BS) begin
                        state_d = DONE;
                    end else if (seg_last) begin
                        state_d = IDLE;
                    end
                end
            end

            DONE: begin
                if (rem_q != '0) begin
                    o_pwqe_wb   = 1'b1;
                    o_pwqe_addr = addr_q;
                    o_pwqe      = {1'b1, opaque_q, rem_q, raddr_q, laddr_q};
                end else begin
                    o_slot_free      = 1'b1;
                    o_slot_free_addr = addr_q;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wqe_segmenter.sv
// tb/tb_wqe_segmenter.sv - scoreboard bench for wqe_segmenter

module tb_wqe_segmenter;
    import wqe_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         i_wqe_cache_empty;
    logic         o_wqe_cache_rd;
    logic         i_wqe_val;
    logic         i_wqe_type;
    logic [1:0]   i_wqe_addr;
    logic [511:0] i_wqe;
    logic         o_pwqe_wb;
    logic [1:0]   o_pwqe_addr;
    logic [511:0] o_pwqe;
    logic         o_slot_free;
    logic [1:0]   o_slot_free_addr;
    logic         o_pkt_val;
    logic         i_pkt_rdy;
    logic [63:0]  o_pkt_laddr;
    logic [63:0]  o_pkt_raddr;
    logic [31:0]  o_pkt_len;
    logic         o_pkt_type;
    logic         o_pkt_first;
    logic         o_pkt_last;
    logic         o_err;

    wqe_segmenter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_wqe_cache_empty (i_wqe_cache_empty),
        .o_wqe_cache_rd    (o_wqe_cache_rd),
        .i_wqe_val         (i_wqe_val),
        .i_wqe_type        (i_wqe_type),
        .i_wqe_addr        (i_wqe_addr),
        .i_wqe             (i_wqe),
        .o_pwqe_wb         (o_pwqe_wb),
        .o_pwqe_addr       (o_pwqe_addr),
        .o_pwqe            (o_pwqe),
        .o_slot_free       (o_slot_free),
        .o_slot_free_addr  (o_slot_free_addr),
        .o_pkt_val         (o_pkt_val),
        .i_pkt_rdy         (i_pkt_rdy),
        .o_pkt_laddr       (o_pkt_laddr),
        .o_pkt_raddr       (o_pkt_raddr),
        .o_pkt_len         (o_pkt_len),
        .o_pkt_type        (o_pkt_type),
        .o_pkt_first       (o_pkt_first),
        .o_pkt_last        (o_pkt_last),
        .o_err             (o_err)
    );

    typedef struct {
        logic [63:0] laddr;
        logic [63:0] raddr;
        logic [31:0] len;
        logic        typ;
        logic        first;
        logic        last;
    } pkt_t;

    typedef struct {
        logic         is_wb;
        logic [1:0]   addr;
        logic [511:0] pwqe;
    } ev_t;

    pkt_t         pkt_q[$];
    ev_t          ev_q[$];
    logic [511:0] last_wb;
    int           n_cmp;
    int           n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_wqe(input logic fb, input logic [31:0] seed,
                                            input logic [63:0] la, input logic [63:0] ra,
                                            input logic [31:0] len);
        logic [511:0] w;
        w = '0;
        for (int i = 0; i < 11; i++) w[160 + 32*i +: 32] = seed ^ (32'(i) * 32'h0101_0101);
        w[63:0]    = la;
        w[127:64]  = ra;
        w[159:128] = len;
        w[FIRST_BIT] = fb;
        return w;
    endfunction

    // Reference segmentation: queues every descriptor and the BS end-of-visit event.
    task automatic model(input logic typ, input logic [1:0] a, input logic [511:0] w);
        logic [63:0] la, ra;
        logic [31:0] rem, seg;
        logic        first, last;
        pkt_t        p;
        ev_t         e;
        la    = w[63:0];
        ra    = w[127:64];
        rem   = w[159:128];
        first = ~w[FIRST_BIT];
        do begin
            seg     = (rem > 32'd4096) ? 32'd4096 : rem;
            last    = (rem <= 32'd4096);
            p.laddr = la;
            p.raddr = ra;
            p.len   = seg;
            p.typ   = typ;
            p.first = first;
            p.last  = last;
            pkt_q.push_back(p);
            la    = la + 64'(seg);
            ra    = ra + 64'(seg);
            rem   = rem - seg;
            first = 1'b0;
        end while (typ == TYPE_LS && !last);
        if (typ == TYPE_BS) begin
            e.is_wb = (rem != 32'd0);
            e.addr  = a;
            e.pwqe  = e.is_wb ? {1'b1, w[510:160], rem, ra, la} : '0;
            ev_q.push_back(e);
            last_wb = e.pwqe;
        end
    endtask

    always @(negedge clk) begin : monitor
        pkt_t p;
        ev_t  e;
        if (rst_n) begin
            if (o_pkt_val && i_pkt_rdy) begin
                chk("pkt_expected", pkt_q.size() != 0, 1'b1);
                if (pkt_q.size() != 0) begin
                    p = pkt_q.pop_front();
                    chk("pkt_laddr", o_pkt_laddr, p.laddr);
                    chk("pkt_raddr", o_pkt_raddr, p.raddr);
                    chk("pkt_len",   o_pkt_len,   p.len);
                    chk("pkt_type",  o_pkt_type,  p.typ);
                    chk("pkt_first", o_pkt_first, p.first);
                    chk("pkt_last",  o_pkt_last,  p.last);
                end
            end
            if (o_pwqe_wb || o_slot_free) begin
                chk("ev_expected", ev_q.size() != 0, 1'b1);
                if (ev_q.size() != 0) begin
                    e = ev_q.pop_front();
                    chk("ev_kind", {o_pwqe_wb, o_slot_free}, e.is_wb ? 2'b10 : 2'b01);
                    if (e.is_wb) begin
                        chk("wb_addr", o_pwqe_addr, e.addr);
                        chk("wb_pwqe", o_pwqe, e.pwqe);
                    end else begin
                        chk("free_addr", o_slot_free_addr, e.addr);
                    end
                end
            end
        end
    end

    // Waits for the pop, then delivers the WQE lat cycles after the pop strobe.
    task automatic deliver(input logic typ, input logic [1:0] a, input logic [511:0] w,
                           input int lat);
        int n;
        n = 0;
        i_wqe_cache_empty = 1'b0;
        while (!o_wqe_cache_rd && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pop_rd", o_wqe_cache_rd, 1'b1);
        i_wqe_cache_empty = 1'b1;
        repeat (lat) @(posedge clk);
        #1;
        i_wqe_type = typ;
        i_wqe_addr = a;
        i_wqe      = w;
        i_wqe_val  = 1'b1;
        @(posedge clk); #1;
        i_wqe_val  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((pkt_q.size() != 0 || ev_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drained"}, 32'(pkt_q.size() + ev_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_quiet"}, {o_pkt_val, o_pwqe_wb, o_slot_free, o_wqe_cache_rd}, 4'b0);
    endtask

    task automatic wait_pkt_val(input string tag);
        int n;
        n = 0;
        while (!o_pkt_val && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, o_pkt_val, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pwqe"}, o_pwqe, '0);
        chk({tag, "_ctl"}, {o_wqe_cache_rd, o_pwqe_wb, o_pwqe_addr, o_slot_free,
                            o_slot_free_addr, o_pkt_val, o_pkt_laddr, o_pkt_raddr,
                            o_pkt_len, o_pkt_type, o_pkt_first, o_pkt_last, o_err}, '0);
    endtask

    initial begin
        logic [511:0] w;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_wqe_cache_empty = 1'b1;
        i_wqe_val  = 1'b0;
        i_wqe_type = TYPE_LS;
        i_wqe_addr = 2'd0;
        i_wqe      = '0;
        i_pkt_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LS 10000 bytes: three descriptors, no write-back or free.
        w = mk_wqe(1'b0, 32'h1111_0000, 64'h0000_0000_1000_0000, 64'hA000_0000_0000_0000, 32'd10000);
        model(TYPE_LS, 2'd0, w);
        deliver(TYPE_LS, 2'd0, w, 1);
        drain("ls10000");

        // BS 9000 bytes in slot 2 over three visits.
        w = mk_wqe(1'b0, 32'h2222_0000, 64'h0000_0002_0000_0000, 64'hFFFF_FFFF_FFFF_F800, 32'd9000);
        model(TYPE_BS, 2'd2, w);
        deliver(TYPE_BS, 2'd2, w, 2);
        drain("bs9000_v1");
        w = last_wb;
        model(TYPE_BS, 2'd2, w);
        deliver(TYPE_BS, 2'd2, w, 1);
        drain("bs9000_v2");
        w = last_wb;
        model(TYPE_BS, 2'd2, w);
        deliver(TYPE_BS, 2'd2, w, 3);
        drain("bs9000_v3");

        // Exactly one MTU, BS slot 0.
        w = mk_wqe(1'b0, 32'h3333_0000, 64'h0000_0000_0000_4000, 64'h0000_0000_0008_0000, 32'd4096);
        model(TYPE_BS, 2'd0, w);
        deliver(TYPE_BS, 2'd0, w, 1);
        drain("bs4096");

        // Zero length, LS and BS (slot 3).
        w = mk_wqe(1'b0, 32'h4444_0000, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0200, 32'd0);
        model(TYPE_LS, 2'd0, w);
        deliver(TYPE_LS, 2'd0, w, 1);
        drain("ls0");
        w = mk_wqe(1'b0, 32'h5555_0000, 64'h0000_0000_0000_0300, 64'h0000_0000_0000_0400, 32'd0);
        model(TYPE_BS, 2'd3, w);
        deliver(TYPE_BS, 2'd3, w, 2);
        drain("bs0");

        // Back-pressure: descriptor held for 7 cycles, no further pop while busy.
        i_pkt_rdy = 1'b0;
        w = mk_wqe(1'b0, 32'h6666_0000, 64'h0000_0000_0020_0000, 64'h0000_0000_0030_0000, 32'd10000);
        model(TYPE_LS, 2'd1, w);
        deliver(TYPE_LS, 2'd1, w, 1);
        wait_pkt_val("stall_val_seen");
        i_wqe_cache_empty = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            chk("stall_val",   o_pkt_val,      1'b1);
            chk("stall_laddr", o_pkt_laddr,    pkt_q[0].laddr);
            chk("stall_raddr", o_pkt_raddr,    pkt_q[0].raddr);
            chk("stall_len",   o_pkt_len,      pkt_q[0].len);
            chk("stall_flags", {o_pkt_type, o_pkt_first, o_pkt_last},
                               {pkt_q[0].typ, pkt_q[0].first, pkt_q[0].last});
            chk("stall_no_pop", o_wqe_cache_rd, 1'b0);
        end
        i_wqe_cache_empty = 1'b1;
        i_pkt_rdy = 1'b1;
        drain("stall");

        // Spurious delivery while idle raises a sticky error.
        i_wqe_val = 1'b1;
        @(posedge clk); #1;
        i_wqe_val = 1'b0;
        chk("err_set", o_err, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", o_err, 1'b1);
        chk("err_no_pkt", {o_pkt_val, o_wqe_cache_rd}, 2'b00);

        // Reset in the middle of a 3-segment LS WQE.
        i_pkt_rdy = 1'b0;
        w = mk_wqe(1'b0, 32'h7777_0000, 64'h0000_0000_0040_0000, 64'h0000_0000_0050_0000, 32'd10000);
        model(TYPE_LS, 2'd0, w);
        deliver(TYPE_LS, 2'd0, w, 1);
        wait_pkt_val("rst_val_seen");
        i_pkt_rdy = 1'b1;
        @(posedge clk); #1;
        chk("rst_seg2_pending", pkt_q.size() != 0 && o_pkt_val, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        pkt_q.delete();
        ev_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("midrst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        w = mk_wqe(1'b0, 32'h8888_0000, 64'h0000_0000_0060_0000, 64'h0000_0000_0070_0000, 32'd5000);
        model(TYPE_LS, 2'd0, w);
        deliver(TYPE_LS, 2'd0, w, 2);
        drain("post_rst");
        chk("post_rst_err_clear", o_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
